dds_sine_meter: RTL and testbench

//  Receive end of the DDS sine path: takes the 8-bit unsigned sine sample stream, one sample per clk.

---
 rtl/dds_pkg.sv | 17 +
 rtl/dds_hyst_cross.sv | 30 +++
 rtl/dds_sine_meter.sv | 142 ++++++++++++++
 tb/tb_dds_sine_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants for the DDS sine receive meter: default midscale,
// period-to-step decode thresholds and the two-state FSM encoding.
package dds_pkg;

  localparam int MID_DEF = 128;

  // Lower bounds of the period bands for steps 1, 2 and 3 (step_est 0, 1, 2)
  localparam int THR_S0 = 192;
  localparam int THR_S1 = 107;
  localparam int THR_S2 = 75;

  typedef enum logic {
    SEEK = 1'b0,
    MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/dds_hyst_cross.sv
// Rising midscale crossing detector with hysteresis: the detector arms below
// MID-HYST and fires once when the sample reaches MID+HYST.
module dds_hyst_cross #(
  parameter int DATA_W = 8,
  parameter int MID    = 128,
  parameter int HYST   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wave,
  output logic              rise
);

  localparam logic [DATA_W-1:0] RISE_LVL = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] ARM_LVL  = DATA_W'(MID - HYST);

  logic armed;

  assign rise = armed && (wave >= RISE_LVL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      armed <= 1'b0;
    else if (rise)
      armed <= 1'b0;
    else if (wave <= ARM_LVL)
      armed <= 1'b1;
  end

endmodule

// File: rtl/dds_sine_meter.sv
// Period meter for the DDS sine loopback: measures clocks between rising
// crossings, decodes the phase step and flags lock. DDS_METER_AVG_EN averages 4 periods.
module dds_sine_meter
  import dds_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MID     = MID_DEF,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wave,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [1:0]       step_est,
  output logic             lock
);

  localparam int DATA_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [1:0] decode_step(input logic [CNT_W-1:0] p);
    if (p >= CNT_W'(THR_S0))
      return 2'd0;
    else if (p >= CNT_W'(THR_S1))
      return 2'd1;
    else if (p >= CNT_W'(THR_S2))
      return 2'd2;
    else
      return 2'd3;
  endfunction

  state_t           state, state_nxt;
  logic             rise_p0;
  logic             start_p0, meas_p0, tmo_p0;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_new_p0, p_out_p0;
  logic [1:0]       s_new_p0;
  logic             upd_p0;
  logic             prev_ok;

  dds_hyst_cross #(
    .DATA_W (DATA_W),
    .MID    (MID),
    .HYST   (HYST)
  ) u_cross (
    .clk  (clk),
    .rst  (rst),
    .wave (wave),
    .rise (rise_p0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= SEEK;
    else
      state <= state_nxt;
  end

  // A rise in the same cycle as the timeout keeps the measurement alive
  always_comb begin
    state_nxt = state;
    case (state)
      SEEK:    if (rise_p0) state_nxt = MEAS;
      MEAS:    if (!rise_p0 && (cnt == TIMEOUT_C)) state_nxt = SEEK;
      default: state_nxt = SEEK;
    endcase
  end

  always_comb begin
    start_p0 = (state == SEEK) && rise_p0;
    meas_p0  = (state == MEAS) && rise_p0;
    tmo_p0   = (state == MEAS) && !rise_p0 && (cnt == TIMEOUT_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (start_p0 || meas_p0)
      cnt <= '0;
    else if (state == MEAS)
      cnt <= sat_inc(cnt);
  end

  assign p_new_p0 = sat_inc(cnt);

`ifdef DDS_METER_AVG_EN
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] acc_sum_p0;
  logic [1:0]       idx;

  assign acc_sum_p0 = acc + {2'b00, p_new_p0};
  assign upd_p0     = meas_p0 && (idx == 2'd3);
  assign p_out_p0   = acc_sum_p0[CNT_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      idx <= 2'd0;
    end else if (tmo_p0) begin
      acc <= '0;
      idx <= 2'd0;
    end else if (meas_p0) begin
      acc <= (idx == 2'd3) ? '0 : acc_sum_p0;
      idx <= idx + 2'd1;
    end
  end
`else
  assign upd_p0   = meas_p0;
  assign p_out_p0 = p_new_p0;
`endif

  assign s_new_p0 = decode_step(p_out_p0);

  // ---- stage p1: registered outputs, one clk after the rising sample ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      step_est     <= 2'd0;
      lock         <= 1'b0;
      prev_ok      <= 1'b0;
    end else begin
      period_valid <= upd_p0;
      if (upd_p0) begin
        period   <= p_out_p0;
        step_est <= s_new_p0;
        lock     <= prev_ok && (s_new_p0 == step_est);
        prev_ok  <= 1'b1;
      end else if (tmo_p0) begin
        lock    <= 1'b0;
        prev_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_sine_meter.sv
// Self-checking bench for dds_sine_meter: a rise-timestamp model checked every
// cycle, plus directed DDS sine scenarios with literal expectations.
`timescale 1ns/1ps
module tb_dds_sine_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1023;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       wave = 8'd0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [1:0]       step_est;
  logic             lock;

  dds_sine_meter #(
    .CNT_W   (CNT_W),
    .MID     (128),
    .HYST    (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wave         (wave),
    .period       (period),
    .period_valid (period_valid),
    .step_est     (step_est),
    .lock         (lock)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  logic [7:0] ph = 8'd0;

  // Model: rise events time-stamped by sample index; period is the gap between them
  int   cyc;
  bit   m_armed, m_meas, m_prev_ok;
  int   m_last;
  int   q[$];
  int   e_period, e_step;
  bit   e_valid, e_lock;

  function automatic int dec(input int p);
    if (p >= 192) return 0;
    if (p >= 107) return 1;
    if (p >= 75)  return 2;
    return 3;
  endfunction

  function automatic int sine(input logic [7:0] p);
    real r;
    r = 128.0 + 127.0 * $sin(6.283185307179586 * real'(int'(p)) / 256.0);
    return int'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
    checks++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_meas = 0; m_prev_ok = 0; m_last = 0;
    q.delete();
    e_period = 0; e_step = 0; e_valid = 0; e_lock = 0;
  endtask

  task automatic emit(input int p_in);
    int p, s;
    p = p_in;
`ifdef DDS_METER_AVG_EN
    q.push_back(p);
    if (q.size() < 4) return;
    p = (q[0] + q[1] + q[2] + q[3]) / 4;
    q.delete();
`endif
    s         = dec(p);
    e_lock    = m_prev_ok && (s == e_step);
    e_step    = s;
    e_period  = p;
    e_valid   = 1;
    m_prev_ok = 1;
  endtask

  task automatic model_update(input int v);
    bit rise;
    int k;
    cyc++;
    e_valid = 0;
    rise = m_armed && (v >= 136);
    if (rise) m_armed = 0;
    else if (v <= 120) m_armed = 1;
    if (m_meas) begin
      k = cyc - m_last;
      if (rise) begin
        m_last = cyc;
        emit(k);
      end else if (k == TIMEOUT + 1) begin
        m_meas = 0; e_lock = 0; m_prev_ok = 0;
        q.delete();
      end
    end else if (rise) begin
      m_meas = 1;
      m_last = cyc;
    end
  endtask

  task automatic drive(input int v);
    wave = 8'(v);
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(v);
    #1;
  endtask

  task automatic gen(input int stp, input int n, input int budget, input bit noisy);
    int got, c, v;
    got = 0; c = 0;
    while (got < n && c < budget) begin
      v = sine(ph);
      if (noisy) v = v + int'($urandom_range(0, 8)) - 4;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      drive(v);
      ph = ph + 8'(stp);
      c++;
      if (period_valid === 1'b1) got++;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL pulse_wait: got %0d pulses expected %0d within %0d clk", got, n, budget);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("period", 32'(period), e_period);
      chk("period_valid", 32'(period_valid), 32'(e_valid));
      chk("step_est", 32'(step_est), e_step);
      chk("lock", 32'(lock), 32'(e_lock));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    repeat (3) drive(0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(period_valid), 0);
    chk("rst_step", 32'(step_est), 0);
    chk("rst_lock", 32'(lock), 0);
    cmp_en = 1'b1;
    rst = 1'b1;

`ifndef DDS_METER_AVG_EN
    // Ideal sine, step 1
    gen(1, 1, 800, 0);
    chk("t1_period", 32'(period), 256);
    chk("t1_step", 32'(step_est), 0);
    chk("t1_lock_first", 32'(lock), 0);
    for (int i = 0; i < 2; i++) begin
      gen(1, 1, 300, 0);
      chk("t1_period_n", 32'(period), 256);
      chk("t1_lock_n", 32'(lock), 1);
    end

    // Flat midscale: timeout to SEEK, period holds
    repeat (TIMEOUT + 20) drive(128);
    chk("t4_lock", 32'(lock), 0);
    chk("t4_period_hold", 32'(period), 256);
    chk("t4_step_hold", 32'(step_est), 0);

    // Step 3: periods 85/86
    gen(3, 1, 800, 0);
    chk("t2_lock_first", 32'(lock), 0);
    for (int i = 0; i < 3; i++) begin
      gen(3, 1, 200, 0);
      chk_rng("t2_period", 32'(period), 85, 86);
      chk("t2_step", 32'(step_est), 2);
      chk("t2_lock", 32'(lock), 1);
    end

    // Step 4 then switch to step 2
    gen(4, 3, 400, 0);
    chk("t3_step4", 32'(step_est), 3);
    chk("t3_lock4", 32'(lock), 1);
    gen(2, 1, 200, 0);
    chk_rng("t3_period_sw", 32'(period), 126, 129);
    chk("t3_step_sw", 32'(step_est), 1);
    chk("t3_lock_sw", 32'(lock), 0);
    gen(2, 1, 200, 0);
    chk("t3_period_2", 32'(period), 128);
    chk("t3_lock_2", 32'(lock), 1);

    // Noisy step 2
    for (int i = 0; i < 5; i++) begin
      gen(2, 1, 200, 1);
      chk_rng("t5_period", 32'(period), 126, 130);
      chk("t5_step", 32'(step_est), 1);
      chk("t5_lock", 32'(lock), 1);
    end

    // Mid-measurement reset
    repeat (20) begin
      drive(sine(ph));
      ph = ph + 8'd1;
    end
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_period", 32'(period), 0);
    chk("t6_valid", 32'(period_valid), 0);
    chk("t6_step", 32'(step_est), 0);
    chk("t6_lock", 32'(lock), 0);
    repeat (3) begin
      drive(sine(ph));
      ph = ph + 8'd1;
    end
    rst = 1'b1;
    gen(1, 1, 800, 0);
    chk("t6_period_after", 32'(period), 256);
    chk("t6_lock_after", 32'(lock), 0);
    gen(1, 1, 300, 0);
    chk("t6_lock_again", 32'(lock), 1);
`else
    // Averaged step 3: four of 85/86 average to 85
    gen(3, 1, 3000, 0);
    chk("avg_period", 32'(period), 85);
    chk("avg_step", 32'(step_est), 2);
    chk("avg_lock_first", 32'(lock), 0);
    gen(3, 1, 1500, 0);
    chk("avg_period_2", 32'(period), 85);
    chk("avg_lock_2", 32'(lock), 1);
    repeat (TIMEOUT + 20) drive(128);
    chk("avg_tmo_lock", 32'(lock), 0);
`endif

    @(posedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
